// File: rtl/lambda_argmax.sv
// Running argmax over one window of WIN_LEN valid lambda samples; result one cycle after the last sample.
// No backpressure: samples are consumed whenever lambda_valid is high in the start cycle or while searching.
module lambda_argmax #(
  parameter int WIN_LEN  = 80,
  parameter int LAMBDA_W = 14,
  localparam int IDX_W   = $clog2(WIN_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LAMBDA_W-1:0] lambda_in,
  input  logic                lambda_valid,
  output logic [IDX_W-1:0]    theta_out,
  output logic [LAMBDA_W-1:0] lambda_max_out,
  output logic                out_valid,
  output logic                busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                      state_q;
  logic [IDX_W-1:0]            idx_q;
  logic [IDX_W-1:0]            theta_q;
  logic signed [LAMBDA_W-1:0]  max_q;
  logic [IDX_W-1:0]            theta_out_q;
  logic [LAMBDA_W-1:0]         lambda_max_out_q;
  logic                        out_valid_q;
  logic                        busy_q;

  logic [IDX_W-1:0]            cur_idx_d;
  logic                        accept_d;
  logic                        take_d;
  logic                        last_d;

  // A start always rebases the index, so its own sample (if any) is index 0.
  always_comb begin
    cur_idx_d = start ? '0 : idx_q;
    accept_d  = lambda_valid && (start || (state_q == SEARCH));
    take_d    = (cur_idx_d == '0) || ($signed(lambda_in) > max_q);
    last_d    = accept_d && (cur_idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      theta_q          <= '0;
      max_q            <= '0;
      theta_out_q      <= '0;
      lambda_max_out_q <= '0;
      out_valid_q      <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept_d && take_d) begin
        max_q   <= lambda_in;
        theta_q <= cur_idx_d;
      end
      if (last_d) begin
        state_q          <= DONE;
        idx_q            <= '0;
        out_valid_q      <= 1'b1;
        busy_q           <= 1'b0;
        theta_out_q      <= take_d ? cur_idx_d : theta_q;
        lambda_max_out_q <= take_d ? lambda_in : max_q;
      end else if (start) begin
        state_q <= SEARCH;
        idx_q   <= accept_d ? IDX_W'(1) : '0;
        busy_q  <= 1'b1;
      end else if (state_q == SEARCH) begin
        busy_q <= 1'b1;
        if (accept_d) begin
          idx_q <= cur_idx_d + IDX_W'(1);
        end
      end else begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  assign theta_out      = theta_out_q;
  assign lambda_max_out = lambda_max_out_q;
  assign out_valid      = out_valid_q;
  assign busy           = busy_q;

endmodule
